// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the command master FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: one command in, one AXI read/write out, one response back.
// Latency: accept at edge N -> AXI valids from N+1 -> rsp_valid after N+2 with a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready; timeout aborts stuck handshakes.
//
// Ports:
//   M_AXI_ACLK / M_AXI_ARESETN       clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_*       command in (write flag, byte address, data, strobes)
//   rsp_valid/rsp_ready, rsp_*       response out (write echo, read data, resp code, timeout flag)
//   M_AXI_AW*/W*/B*/AR*/R*           AXI4-Lite master channels, PROT tied to 0
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  // Keep at least one counter bit so a disabled timeout still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                            state;
  logic                              cmd_ready_q, rsp_valid_q, write_q, timeout_q;
  logic                              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                              aw_done, w_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, rdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic [1:0]                        resp_q;
  logic [CNT_W-1:0]                  cnt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_fin, w_fin;
  logic waiting, timeout_hit, abort;

  assign aw_hs  = awvalid_q && M_AXI_AWREADY;
  assign w_hs   = wvalid_q  && M_AXI_WREADY;
  assign b_hs   = bready_q  && M_AXI_BVALID;
  assign ar_hs  = arvalid_q && M_AXI_ARREADY;
  assign r_hs   = rready_q  && M_AXI_RVALID;
  // A channel counts as finished if it completed earlier or completes this cycle.
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done  || w_hs;

  assign waiting     = (state == WR_REQ) || (state == WR_RESP) ||
                       (state == RD_REQ) || (state == RD_DATA);
  // cnt holds the number of completed waiting cycles; the edge ending cycle
  // TIMEOUT_CYCLES aborts unless the pending handshake lands on that same edge.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    abort = 1'b0;
    case (state)
      WR_REQ:  abort = timeout_hit && !(aw_fin && w_fin);
      WR_RESP: abort = timeout_hit && !b_hs;
      RD_REQ:  abort = timeout_hit && !ar_hs;
      RD_DATA: abort = timeout_hit && !r_hs;
      default: abort = 1'b0;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      timeout_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      cnt         <= '0;
    end else begin
      if (waiting) cnt <= cnt + 1'b1;

      if (abort) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        rdata_q     <= '0;
        resp_q      <= RESP_DECERR;
        timeout_q   <= 1'b1;
        rsp_valid_q <= 1'b1;
        state       <= RSP;
      end else begin
        case (state)
          IDLE: begin
            cmd_ready_q <= 1'b1;
            if (cmd_valid && cmd_ready_q) begin
              cmd_ready_q <= 1'b0;
              addr_q      <= cmd_addr;
              wdata_q     <= cmd_wdata;
              wstrb_q     <= cmd_wstrb;
              write_q     <= cmd_write;
              cnt         <= '0;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              if (cmd_write) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state     <= WR_REQ;
              end else begin
                arvalid_q <= 1'b1;
                state     <= RD_REQ;
              end
            end
          end
          WR_REQ: begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            aw_done <= aw_fin;
            w_done  <= w_fin;
            if (aw_fin && w_fin) begin
              bready_q <= 1'b1;
              state    <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (b_hs) begin
              bready_q    <= 1'b0;
              resp_q      <= M_AXI_BRESP;
              rdata_q     <= '0;
              timeout_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state       <= RSP;
            end
          end
          RD_REQ: begin
            if (ar_hs) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state     <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (r_hs) begin
              rready_q    <= 1'b0;
              rdata_q     <= M_AXI_RDATA;
              resp_q      <= M_AXI_RRESP;
              timeout_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state       <= RSP;
            end
          end
          RSP: begin
            if (rsp_ready) begin
              rsp_valid_q <= 1'b0;
              cmd_ready_q <= 1'b1;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = timeout_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

AXI4-Lite initiator that turns single-word command requests into AXI4-Lite read or write transactions and returns one response per command. It sits between the debugger's host command decoder (UART/packet side) and the memory-mapped register slaves such as the 4x32 mmap register file. It is the master end of the same bus those slaves implement.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 4: AXI address width.
- `C_M_AXI_DATA_WIDTH`, 32: data width. Only 32 is supported.
- `TIMEOUT_CYCLES`, 256: maximum wait for any AXI handshake. 0 disables the timeout.

Ports:
- `M_AXI_ACLK`  in  1: single clock. All logic is on the rising edge.
- `M_AXI_ARESETN`  in  1: reset, asynchronous, active-low.
- `cmd_valid` / `cmd_ready`  in/out  1: command handshake.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH: byte address.
- `cmd_wdata`  in  32: write data. Ignored for reads.
- `cmd_wstrb`  in  4: write byte strobes. Ignored for reads.
- `rsp_valid` / `rsp_ready`  out/in  1: response handshake.
- `rsp_write`  out  1: echo of `cmd_write` for this response.
- `rsp_rdata`  out  32: read data. 0 for writes and for timeouts.
- `rsp_resp`  out  2: BRESP/RRESP, or DECERR on timeout.
- `rsp_timeout`  out  1: the transaction was aborted by the timeout.
- `M_AXI_AW*` (ADDR, PROT, VALID, READY), `M_AXI_W*` (DATA, STRB, VALID, READY), `M_AXI_B*` (RESP, VALID, READY), `M_AXI_AR*` (ADDR, PROT, VALID, READY), `M_AXI_R*` (DATA, RESP, VALID, READY): standard AXI4-Lite master ports. `AWPROT` and `ARPROT` are tied to 3'b000.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid`: register addr, wdata, wstrb and write; clear the timeout counter.
  - Go to WR_REQ or RD_REQ.
- WR_REQ:
  - Drive `AWVALID` = `WVALID` = 1 with the registered address, data and strobe.
  - Each VALID drops on its own handshake; `aw_done` and `w_done` flags track completion.
  - The two handshakes may complete in either order or in the same cycle.
  - When both flags are set, go to WR_RESP.
- WR_RESP:
  - `BREADY` = 1.
  - On `BVALID`: capture BRESP and go to RSP.
- RD_REQ:
  - `ARVALID` = 1.
  - On `ARREADY`, go to RD_DATA.
- RD_DATA:
  - `RREADY` = 1.
  - On `RVALID`: capture RDATA and RRESP, go to RSP.
- RSP:
  - `rsp_valid` = 1, outputs held stable.
  - On `rsp_ready`, return to IDLE.
- Timeout:
  - The counter increments every cycle spent in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
  - When the count reaches `TIMEOUT_CYCLES`: drop all AXI VALID/READY signals and go to RSP with `rsp_resp` = DECERR (2'b11), `rsp_timeout` = 1, `rsp_rdata` = 0.
  - This is a debugger recovery path. The slave must be reset before it is used again.
- There is one outstanding transaction at a time. No new command is accepted until the response handshake completes.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE. All AXI VALID/READY outputs 0, `rsp_valid` = 0, `cmd_ready` = 0 while reset is asserted, all data/resp outputs 0.
- Command accepted at edge N:
  - AXI VALIDs are high from N+1, driven from registers (no combinational path from `cmd_*`).
- Write with an always-ready slave: AW/W handshake at N+1, B handshake at N+2, `rsp_valid` at N+3.
- Read with a zero-wait slave: AR handshake at N+1, R handshake at N+2, `rsp_valid` at N+3.
- BREADY and RREADY are never asserted before their request handshake has completed.
- Once asserted, a VALID is held until its handshake completes, except when the timeout aborts.
- Reset mid-transaction: all outputs drop immediately and the command in flight is lost with no response.

## Structure
- Shared package `axi_lite_pkg` holds:
  - Response code constants: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - The state enum type.
- No sub-module is needed. The timeout counter is inline, `$clog2(TIMEOUT_CYCLES+1)` bits wide.

## Test plan
- Bench: this block drives `axi_slave_mmap_4x32_r4`. The reset pin of `axi_slave_mmap_4x32_r4` is active-high, so it is driven from `!M_AXI_ARESETN`.
- Write 0x0 = 0xDEADBEEF with strb 0xF, then read 0x0 -> write response OKAY; read gives `rsp_rdata` = 0xDEADBEEF, `rsp_resp` = 0, minimum latency 3 cycles from accept to `rsp_valid`.
- Write 0x0 = 0x000000FF with strb 0x1, then read -> 0xDEADBEFF. Write 0x4 = 0xAA000000 with strb 0x8 over a prior 0x12345678 -> 0xAA345678.
- Slave stub where WREADY comes 3 cycles before AWREADY, then the reverse order -> each VALID drops on its own handshake, BREADY rises only after both, exactly one response.
- `rsp_ready` held low for 10 cycles -> `rsp_valid` and `rsp_rdata` stay stable, `cmd_ready` = 0, no AXI activity.
- Unresponsive slave with `TIMEOUT_CYCLES` = 16 -> after 16 cycles: all VALIDs 0, `rsp_resp` = 2'b11, `rsp_timeout` = 1.
- Assert `M_AXI_ARESETN` low during WR_REQ -> `AWVALID`, `WVALID` and `rsp_valid` go to 0 in the same cycle. After release, a read of 0x0 returns 0x00000000.
